rob_complete_arbiter: RTL and testbench

- Shares the ROB's completion-update path between N_REQ completing units: exe, mem and the hilo unit.
- Each unit pushes completion records into its own small FIFO. A round-robin arbiter drains at most one record per cycle into registered outputs, which drive the ROB's completion-flag / instr_num / alt-PC inputs.
- Sits between the execution back end and the ROB. Obeys the ROB's flush and the pipeline stall.

---
 rtl/rob_complete_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_rob_complete_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_complete_arbiter.sv
// Round-robin merge of per-unit completion FIFOs onto the ROB's single completion-update port.
// Records with instr_num==0 are accepted but discarded and counted, since 0 means "empty" in the ROB.
module rob_complete_arbiter #(
    parameter int N_REQ      = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int SRC_W      = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  flush,
    input  logic                  stall,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_instr_num,
    input  logic [32*N_REQ-1:0]   req_alt_pc,
    input  logic [N_REQ-1:0]      req_alt_flag,
    output logic                  cmp_valid,
    output logic [31:0]           cmp_instr_num,
    output logic [31:0]           cmp_alt_pc,
    output logic                  cmp_alt_flag,
    output logic [SRC_W-1:0]      cmp_src,
    output logic [7:0]            drop_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int CW    = SRC_W + 1;

    // Handshake: a requester transfers on a rising edge where req_valid[i] & req_ready[i];
    // req_ready never looks at a same-cycle pop, so a full FIFO stays not-ready while draining.

    logic [N_REQ-1:0]            fifo_full;
    logic [N_REQ-1:0]            fifo_empty;
    logic [N_REQ-1:0]            push_fire;
    logic [N_REQ-1:0]            instr_zero;
    logic [N_REQ-1:0]            store_en;
    logic [N_REQ-1:0]            drop_vec;
    logic [N_REQ-1:0]            pop_vec;
    logic [N_REQ-1:0][31:0]      head_instr;
    logic [N_REQ-1:0][31:0]      head_pc;
    logic [N_REQ-1:0]            head_flag;

    logic                        grant_found;
    logic [SRC_W-1:0]            grant_idx;
    logic [CW-1:0]               cand;
    logic                        pop_en;

    logic [SRC_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                        cmp_valid_q, cmp_valid_d;
    logic [31:0]                 cmp_instr_q, cmp_instr_d;
    logic [31:0]                 cmp_pc_q, cmp_pc_d;
    logic                        cmp_flag_q, cmp_flag_d;
    logic [SRC_W-1:0]            cmp_src_q, cmp_src_d;
    logic [7:0]                  drop_cnt_q, drop_cnt_d;
    logic [8:0]                  drop_sum;

    assign req_ready = ~fifo_full & {N_REQ{~flush}};
    assign push_fire = req_valid & req_ready;
    assign store_en  = push_fire & ~instr_zero;
    assign drop_vec  = push_fire & instr_zero;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_fifo
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [31:0]      instr_mem [FIFO_DEPTH];
            logic [31:0]      pc_mem    [FIFO_DEPTH];
            logic             flag_mem  [FIFO_DEPTH];

            assign instr_zero[g] = (req_instr_num[32*g +: 32] == 32'd0);
            assign fifo_full[g]  = (cnt_q == CNT_W'(FIFO_DEPTH));
            assign fifo_empty[g] = (cnt_q == '0);
            assign head_instr[g] = instr_mem[rd_ptr_q];
            assign head_pc[g]    = pc_mem[rd_ptr_q];
            assign head_flag[g]  = flag_mem[rd_ptr_q];

            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            always_comb begin
                cnt_d    = cnt_q;
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                if (flush) begin
                    cnt_d    = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                end else begin
                    if (store_en[g]) wr_ptr_d = wr_ptr_q + 1'b1;
                    if (pop_vec[g])  rd_ptr_d = rd_ptr_q + 1'b1;
                    case ({store_en[g], pop_vec[g]})
                        2'b10:   cnt_d = cnt_q + 1'b1;
                        2'b01:   cnt_d = cnt_q - 1'b1;
                        default: cnt_d = cnt_q;
                    endcase
                end
            end

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    cnt_q    <= '0;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    cnt_q    <= cnt_d;
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            always_ff @(posedge CLK) begin
                if (store_en[g]) begin
                    instr_mem[wr_ptr_q] <= req_instr_num[32*g +: 32];
                    pc_mem[wr_ptr_q]    <= req_alt_pc[32*g +: 32];
                    flag_mem[wr_ptr_q]  <= req_alt_flag[g];
                end
            end
        end
    endgenerate

    // Scan from rr_ptr upward, wrapping at N_REQ; first non-empty FIFO wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
            if (!grant_found && !fifo_empty[cand[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[SRC_W-1:0];
            end
        end
    end

    assign pop_en = grant_found & ~flush & ~stall;

    always_comb begin
        pop_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pop_vec[i] = pop_en && (grant_idx == SRC_W'(i));
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cmp_valid_d = cmp_valid_q;
        cmp_instr_d = cmp_instr_q;
        cmp_pc_d    = cmp_pc_q;
        cmp_flag_d  = cmp_flag_q;
        cmp_src_d   = cmp_src_q;
        if (flush) begin
            cmp_valid_d = 1'b0;
            rr_ptr_d    = '0;
        end else if (!stall) begin
            if (grant_found) begin
                cmp_valid_d = 1'b1;
                cmp_instr_d = head_instr[grant_idx];
                cmp_pc_d    = head_pc[grant_idx];
                cmp_flag_d  = head_flag[grant_idx];
                cmp_src_d   = grant_idx;
                rr_ptr_d    = (grant_idx == SRC_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end else begin
                cmp_valid_d = 1'b0;
            end
        end
    end

    // One increment per dropped push, several may land on the same edge.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < N_REQ; i++) begin
            if (drop_vec[i]) drop_sum = drop_sum + 9'd1;
        end
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rr_ptr_q    <= '0;
            cmp_valid_q <= 1'b0;
            cmp_instr_q <= '0;
            cmp_pc_q    <= '0;
            cmp_flag_q  <= 1'b0;
            cmp_src_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_instr_q <= cmp_instr_d;
            cmp_pc_q    <= cmp_pc_d;
            cmp_flag_q  <= cmp_flag_d;
            cmp_src_q   <= cmp_src_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign cmp_valid     = cmp_valid_q;
    assign cmp_instr_num = cmp_instr_q;
    assign cmp_alt_pc    = cmp_pc_q;
    assign cmp_alt_flag  = cmp_flag_q;
    assign cmp_src       = cmp_src_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Bench for rob_complete_arbiter: directed vector table, hand-written corner sequences,
// then a randomised phase checked against a queue-based reference model and scoreboard.
module tb_rob_complete_arbiter;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          flush;
    logic          stall;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [95:0]   req_instr_num;
    logic [95:0]   req_alt_pc;
    logic [2:0]    req_alt_flag;
    logic          cmp_valid;
    logic [31:0]   cmp_instr_num;
    logic [31:0]   cmp_alt_pc;
    logic          cmp_alt_flag;
    logic [1:0]    cmp_src;
    logic [7:0]    drop_count;

    rob_complete_arbiter #(.N_REQ(3), .FIFO_DEPTH(2), .SRC_W(2)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .flush         (flush),
        .stall         (stall),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_instr_num (req_instr_num),
        .req_alt_pc    (req_alt_pc),
        .req_alt_flag  (req_alt_flag),
        .cmp_valid     (cmp_valid),
        .cmp_instr_num (cmp_instr_num),
        .cmp_alt_pc    (cmp_alt_pc),
        .cmp_alt_flag  (cmp_alt_flag),
        .cmp_src       (cmp_src),
        .drop_count    (drop_count)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic        flush;
        logic        stall;
        logic [2:0]  valid;
        logic [95:0] instr;
        logic [95:0] pc;
        logic [2:0]  flag;
        logic [2:0]  exp_ready;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_flag;
        logic [1:0]  exp_src;
        logic [7:0]  exp_drop;
    } vec_t;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        flag;
    } rec_t;
    localparam int W = $bits(rec_t);

    logic [W-1:0] exp_q[$];
    rec_t mq0[$];
    rec_t mq1[$];
    rec_t mq2[$];

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic fl, input logic st, input logic [2:0] va,
                         input logic [95:0] in, input logic [95:0] pc, input logic [2:0] fg);
        flush         = fl;
        stall         = st;
        req_valid     = va;
        req_instr_num = in;
        req_alt_pc    = pc;
        req_alt_flag  = fg;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 96'd0, 96'd0, 3'b000);
    endtask

    task automatic chk_out(input string name, input logic [31:0] instr, input logic [31:0] pc,
                           input logic flag, input logic [1:0] src);
        check({name, "_valid"}, cmp_valid, 1);
        check({name, "_instr"}, cmp_instr_num, instr);
        check({name, "_pc"},    cmp_alt_pc, pc);
        check({name, "_flag"},  cmp_alt_flag, flag);
        check({name, "_src"},   cmp_src, src);
    endtask

    function automatic vec_t mk(input logic fl, input logic st, input logic [2:0] va,
                                input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                                input logic [31:0] p0, input logic [2:0] fg, input logic [2:0] er,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                                input logic ef, input logic [1:0] es, input logic [7:0] ed);
        vec_t v;
        v.flush = fl; v.stall = st; v.valid = va;
        v.instr = {i2, i1, i0};
        v.pc    = {64'd0, p0};
        v.flag  = fg;
        v.exp_ready = er; v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep;
        v.exp_flag = ef; v.exp_src = es; v.exp_drop = ed;
        return v;
    endfunction

    function automatic int msize(input int i);
        case (i)
            0:       return mq0.size();
            1:       return mq1.size();
            default: return mq2.size();
        endcase
    endfunction

    task automatic mpush(input int i, input rec_t r);
        case (i)
            0:       mq0.push_back(r);
            1:       mq1.push_back(r);
            default: mq2.push_back(r);
        endcase
    endtask

    task automatic mpop(input int i, output rec_t r);
        case (i)
            0:       r = mq0.pop_front();
            1:       r = mq1.pop_front();
            default: r = mq2.pop_front();
        endcase
    endtask

    rec_t        r;
    rec_t        got;
    logic [2:0]  exp_rdy;
    logic        r_flush, r_stall, m_valid, found, popped;
    int          m_rr, win, idx;
    int          m_drop;
    logic [31:0] rin;

    initial begin
        // clock/reset block
        RESET = 1'b0;
        idle();
        #12;
        check("rst_valid", cmp_valid, 0);
        check("rst_instr", cmp_instr_num, 0);
        check("rst_pc",    cmp_alt_pc, 0);
        check("rst_flag",  cmp_alt_flag, 0);
        check("rst_src",   cmp_src, 0);
        check("rst_drop",  drop_count, 0);
        check("rst_ready", req_ready, 3'b111);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        for (int c = 0; c < 10; c++) begin
            #1;
            check("idle_ready", req_ready, 3'b111);
            tick();
            check("idle_valid", cmp_valid, 0);
            check("idle_drop",  drop_count, 0);
        end

        // directed vector table
        vecs[0]  = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,0, 0,     0,0,0,0);
        vecs[1]  = mk(0,0,3'b001,  5, 0, 0,'h400,3'b001,3'b111,0, 0,     0,0,0,0);
        vecs[2]  = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,1, 5, 'h400,1,0,0);
        vecs[3]  = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,0, 0,     0,0,0,0);
        vecs[4]  = mk(1,0,3'b000,  0, 0, 0,     0,3'b000,3'b000,0, 0,     0,0,0,0);
        vecs[5]  = mk(0,0,3'b111, 10,11,12,'h100,3'b000,3'b111,0, 0,     0,0,0,0);
        vecs[6]  = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,1,10, 'h100,0,0,0);
        vecs[7]  = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,1,11,     0,0,1,0);
        vecs[8]  = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,1,12,     0,0,2,0);
        vecs[9]  = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,0, 0,     0,0,0,0);
        vecs[10] = mk(0,0,3'b001,  0, 0, 0, 'h55,3'b001,3'b111,0, 0,     0,0,0,1);
        vecs[11] = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,0, 0,     0,0,0,1);
        vecs[12] = mk(1,0,3'b111,  7, 8, 9,     0,3'b000,3'b000,0, 0,     0,0,0,1);
        vecs[13] = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,0, 0,     0,0,0,1);
        vecs[14] = mk(0,0,3'b010,  0,33, 0,     0,3'b000,3'b111,0, 0,     0,0,0,1);
        vecs[15] = mk(0,0,3'b101, 34, 0,35,'h340,3'b001,3'b111,1,33,     0,0,1,1);
        vecs[16] = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,1,35,     0,0,2,1);
        vecs[17] = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,1,34, 'h340,1,0,1);
        vecs[18] = mk(0,0,3'b000,  0, 0, 0,     0,3'b000,3'b111,0, 0,     0,0,0,1);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].flush, vecs[i].stall, vecs[i].valid, vecs[i].instr, vecs[i].pc, vecs[i].flag);
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
            tick();
            if (vecs[i].exp_valid) begin
                chk_out($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_pc,
                        vecs[i].exp_flag, vecs[i].exp_src);
            end else begin
                check($sformatf("vec%0d_valid", i), cmp_valid, 0);
            end
            check($sformatf("vec%0d_drop", i), drop_count, vecs[i].exp_drop);
        end

        // backpressure on mem while stalled
        drive(0, 1, 3'b010, {32'd0, 32'd20, 32'd0}, 96'd0, 3'b000);
        #1; check("bp_ready_20", req_ready[1], 1);
        tick();
        drive(0, 1, 3'b010, {32'd0, 32'd21, 32'd0}, 96'd0, 3'b000);
        #1; check("bp_ready_21", req_ready[1], 1);
        tick();
        drive(0, 1, 3'b010, {32'd0, 32'd22, 32'd0}, 96'd0, 3'b000);
        #1; check("bp_ready_22_full", req_ready[1], 0);
        tick();
        check("bp_stall_valid", cmp_valid, 0);
        drive(0, 0, 3'b010, {32'd0, 32'd22, 32'd0}, 96'd0, 3'b000);
        #1; check("bp_ready_popping_full", req_ready[1], 0);
        tick();
        chk_out("bp_out20", 20, 0, 0, 1);
        #1; check("bp_ready_22_ok", req_ready[1], 1);
        tick();
        chk_out("bp_out21", 21, 0, 0, 1);
        idle();
        tick();
        chk_out("bp_out22", 22, 0, 0, 1);
        tick();
        check("bp_drain_valid", cmp_valid, 0);

        // stall holds a valid output record
        drive(0, 0, 3'b001, {64'd0, 32'd30}, {64'd0, 32'h30}, 3'b000);
        tick();
        idle();
        tick();
        chk_out("sh_out30", 30, 'h30, 0, 0);
        drive(0, 1, 3'b001, {64'd0, 32'd31}, {64'd0, 32'h31}, 3'b001);
        tick();
        chk_out("sh_hold1", 30, 'h30, 0, 0);
        drive(0, 1, 3'b000, 96'd0, 96'd0, 3'b000);
        tick();
        chk_out("sh_hold2", 30, 'h30, 0, 0);
        idle();
        tick();
        chk_out("sh_out31", 31, 'h31, 1, 0);
        tick();
        check("sh_drain_valid", cmp_valid, 0);

        // flush with exe=2, mem=1 pending and cmp_valid=1
        drive(0, 0, 3'b100, {32'd60, 64'd0}, 96'd0, 3'b000);
        tick();
        idle();
        tick();
        chk_out("fl_out60", 60, 0, 0, 2);
        drive(0, 1, 3'b011, {32'd0, 32'd50, 32'd40}, 96'd0, 3'b000);
        tick();
        drive(0, 1, 3'b001, {64'd0, 32'd41}, 96'd0, 3'b000);
        tick();
        check("fl_pre_valid", cmp_valid, 1);
        drive(1, 0, 3'b111, {32'd73, 32'd72, 32'd71}, 96'd0, 3'b000);
        #1; check("fl_ready", req_ready, 3'b000);
        tick();
        check("fl_valid", cmp_valid, 0);
        idle();
        for (int c = 0; c < 3; c++) begin
            tick();
            check("fl_after_valid", cmp_valid, 0);
        end
        #1; check("fl_ready_back", req_ready, 3'b111);

        // randomised phase: reference model + scoreboard
        m_rr = 0; m_valid = 1'b0; m_drop = 1;
        for (int c = 0; c < 400; c++) begin
            r_flush = ($urandom_range(0, 49) == 0);
            r_stall = ($urandom_range(0, 5) == 0);
            flush = r_flush;
            stall = r_stall;
            for (int i = 0; i < 3; i++) begin
                req_valid[i] = 1'($urandom_range(0, 1));
                rin = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 1000000));
                req_instr_num[32*i +: 32] = rin;
                req_alt_pc[32*i +: 32]    = (i == 0) ? $urandom : 32'd0;
                req_alt_flag[i]           = (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            #1;
            for (int i = 0; i < 3; i++) exp_rdy[i] = !r_flush && (msize(i) < 2);
            check("rand_ready", req_ready, exp_rdy);
            popped = 1'b0;
            if (r_flush) begin
                mq0.delete(); mq1.delete(); mq2.delete();
                m_rr = 0;
                m_valid = 1'b0;
            end else begin
                if (!r_stall) begin
                    found = 1'b0;
                    win = 0;
                    for (int k = 0; k < 3; k++) begin
                        idx = (m_rr + k) % 3;
                        if (!found && msize(idx) > 0) begin
                            found = 1'b1;
                            win = idx;
                        end
                    end
                    if (found) begin
                        mpop(win, r);
                        exp_q.push_back(r);
                        m_rr = (win + 1) % 3;
                        popped = 1'b1;
                    end
                    m_valid = found;
                end
                for (int i = 0; i < 3; i++) begin
                    if (req_valid[i] && exp_rdy[i]) begin
                        if (req_instr_num[32*i +: 32] == 32'd0) begin
                            if (m_drop < 255) m_drop++;
                        end else begin
                            r.src   = 2'(i);
                            r.instr = req_instr_num[32*i +: 32];
                            r.pc    = req_alt_pc[32*i +: 32];
                            r.flag  = req_alt_flag[i];
                            mpush(i, r);
                        end
                    end
                end
            end
            tick();
            check("rand_valid", cmp_valid, m_valid);
            if (popped) begin
                got = rec_t'(exp_q.pop_front());
                check("rand_instr", cmp_instr_num, got.instr);
                check("rand_pc",    cmp_alt_pc, got.pc);
                check("rand_flag",  cmp_alt_flag, got.flag);
                check("rand_src",   cmp_src, got.src);
            end
        end
        check("rand_drop", drop_count, 32'(m_drop));

        drive(1, 0, 3'b000, 96'd0, 96'd0, 3'b000);
        tick();
        idle();

        // zero instr_num pushes are dropped and counted, saturating
        for (int c = 0; c < 300; c++) begin
            drive(0, 0, 3'b100, 96'd0, 96'd0, 3'b000);
            #1; check("drop_ready2", req_ready[2], 1);
            tick();
            check("drop_valid", cmp_valid, 0);
            if (m_drop < 255) m_drop++;
        end
        check("drop_sat_model", drop_count, 32'(m_drop));
        check("drop_sat_255", drop_count, 255);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
